// File: rtl/kyber_ctrl_pkg.sv
// kyber_ctrl_pkg: op codes, sequencer states and default timing shared by the sequencer and its bench
package kyber_ctrl_pkg;
   typedef enum logic [1:0] {OP_FNTT = 2'd0, OP_PWM2 = 2'd1, OP_INTT = 2'd2, OP_FULL = 2'd3} op_t;
   typedef enum logic [1:0] {IDLE, ISSUE, RUN, DRAIN} state_t;
   localparam int DEF_FNTT_CYCLES = 225;
   localparam int DEF_PWM_CYCLES = 160;
   localparam int DEF_INTT_CYCLES = 225;
   localparam int DEF_DRAIN_CYCLES = 8;
   localparam int DEF_CNT_W = 9;
endpackage

// File: rtl/polymul_sequencer_if.sv
// polymul_sequencer_if: command handshake between a requester and the sequencer
interface polymul_sequencer_if;
   import kyber_ctrl_pkg::*;
   logic cmd_valid;
   op_t cmd_op;
   logic cmd_ready;
   logic abort;
   modport master (output cmd_valid, output cmd_op, output abort, input cmd_ready);
   modport slave (input cmd_valid, input cmd_op, input abort, output cmd_ready);
endinterface

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter that holds at zero, shared by the run and drain windows
module seq_timer import kyber_ctrl_pkg::*; #(
   parameter int CNT_W = DEF_CNT_W
) (
   input logic clk,
   input logic reset,
   input logic clr,
   input logic load,
   input logic [CNT_W-1:0] load_val,
   output logic zero
);
   logic [CNT_W-1:0] cnt;
   // clear beats load; otherwise count down and stick at zero
   always_ff @(posedge clk)
      if (reset || clr) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   assign zero = (cnt == '0);
endmodule

// File: rtl/polymul_sequencer.sv
// polymul_sequencer: accepts one op per handshake, pulses the generator start and times run plus drain
module polymul_sequencer import kyber_ctrl_pkg::*; #(
   parameter int FNTT_CYCLES = DEF_FNTT_CYCLES,
   parameter int PWM_CYCLES = DEF_PWM_CYCLES,
   parameter int INTT_CYCLES = DEF_INTT_CYCLES,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic clk,
   input logic reset,
   polymul_sequencer_if.slave cmd,
   output logic start_fntt,
   output logic start_pwm2,
   output logic start_intt,
   output logic ag_clr,
   output logic busy,
   output logic [1:0] cur_op,
   output logic done
);
   state_t state, state_n;
   op_t sub, sub_n;
   logic full, full_n, t_clr, t_load, t_zero, accept, kill, finish;
   logic [CNT_W-1:0] t_val;
   assign accept = cmd.cmd_valid && cmd.cmd_ready && !cmd.abort;
   assign kill = (state != IDLE) && cmd.abort;
   assign finish = (state == DRAIN) && t_zero && !(full && sub != OP_INTT);
   seq_timer #(.CNT_W(CNT_W)) u_timer (
      .clk(clk),
      .reset(reset),
      .clr(t_clr),
      .load(t_load),
      .load_val(t_val),
      .zero(t_zero)
   );
   // state, current sub-op and FULL-chain flag
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         sub <= OP_FNTT;
         full <= 1'b0;
      end else begin
         state <= state_n;
         sub <= sub_n;
         full <= full_n;
      end
   // next state, sub-op chaining and timer loads; abort overrides everything
   always_comb begin
      state_n = state;
      sub_n = sub;
      full_n = full;
      t_clr = 1'b0;
      t_load = 1'b0;
      t_val = '0;
      if (kill) begin
         state_n = IDLE;
         sub_n = OP_FNTT;
         full_n = 1'b0;
         t_clr = 1'b1;
      end else begin
         unique case (state)
            IDLE: if (accept) begin
               state_n = ISSUE;
               full_n = (cmd.cmd_op == OP_FULL);
               sub_n = full_n ? OP_FNTT : cmd.cmd_op;
            end
            ISSUE: begin
               state_n = RUN;
               t_load = 1'b1;
               t_val = sub == OP_PWM2 ? CNT_W'(PWM_CYCLES - 1) :
                       sub == OP_INTT ? CNT_W'(INTT_CYCLES - 1) : CNT_W'(FNTT_CYCLES - 1);
            end
            RUN: if (t_zero) begin
               state_n = DRAIN;
               t_load = 1'b1;
               t_val = CNT_W'(DRAIN_CYCLES - 1);
            end
            DRAIN: if (t_zero) begin
               state_n = finish ? IDLE : ISSUE;
               sub_n = finish ? OP_FNTT : (sub == OP_FNTT ? OP_PWM2 : OP_INTT);
               full_n = finish ? 1'b0 : full;
            end
         endcase
      end
   end
   // registered outputs derived from the state being entered; reset keeps ag_clr low
   always_ff @(posedge clk)
      if (reset) begin
         cmd.cmd_ready <= 1'b1;
         busy <= 1'b0;
         cur_op <= 2'd0;
         start_fntt <= 1'b0;
         start_pwm2 <= 1'b0;
         start_intt <= 1'b0;
         ag_clr <= 1'b0;
         done <= 1'b0;
      end else begin
         cmd.cmd_ready <= (state_n == IDLE);
         busy <= (state_n != IDLE);
         cur_op <= (state_n == IDLE) ? 2'd0 : 2'(sub_n);
         start_fntt <= (state_n == ISSUE) && (sub_n == OP_FNTT);
         start_pwm2 <= (state_n == ISSUE) && (sub_n == OP_PWM2);
         start_intt <= (state_n == ISSUE) && (sub_n == OP_INTT);
         ag_clr <= kill;
         done <= finish && !kill;
      end
endmodule
